crypto_tx_sequencer: RTL and testbench

CRYPTO_TX_SEQUENCER -- requirements
Module: crypto_tx_sequencer

---
 rtl/crypto_pkg.sv | 15 +
 rtl/req_fifo.sv | 60 ++++++
 rtl/crypto_tx_sequencer.sv | 152 +++++++++++++++
 tb/tb_crypto_tx_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared definitions for the crypto transmit sequencer: FSM encoding and
// the default cipher-wait timeout.
package crypto_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_C  = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    localparam int TMO_DEFAULT = 1023;

endpackage

// File: rtl/req_fifo.sv
// Plaintext request queue. A push into a full queue is still accepted
// when a pop happens in the same cycle.
module req_fifo #(
    parameter int DBITS = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DBITS-1:0]           din,
    output logic [DBITS-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DBITS-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign dout  = mem[rd_ptr];

    // Storage is not reset; an empty count makes its contents irrelevant.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/crypto_tx_sequencer.sv
// Queues button-captured plaintext bytes, runs each through the cipher one at
// a time and hands the ciphertext to the UART transmitter.
module crypto_tx_sequencer
    import crypto_pkg::*;
#(
    parameter int DBITS = 8,
    parameter int DEPTH = 4,
    parameter int TMO   = TMO_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_tick,
    input  logic [DBITS-1:0]           plain_text,
    output logic                       crypto_start,
    output logic [DBITS-1:0]           crypto_pt,
    input  logic                       crypto_done,
    input  logic [DBITS-1:0]           cipher_text,
    output logic                       tx_start,
    output logic [DBITS-1:0]           tx_din,
    input  logic                       tx_done_tick,
    output logic [DBITS-1:0]           last_plain,
    output logic [DBITS-1:0]           last_cipher,
    output logic                       busy,
    output logic                       ovf,
    output logic                       tmo_err,
    input  logic                       err_clr,
    output logic [2:0]                 state,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    state_t           cur_state;
    state_t           next_state;
    logic [TW-1:0]    tmo_cnt;
    logic [DBITS-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;
    logic             done_hit;
    logic             timeout;

    req_fifo #(
        .DBITS(DBITS),
        .DEPTH(DEPTH)
    ) u_req_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (req_tick),
        .pop  (pop),
        .din  (plain_text),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(level)
    );

    assign drop  = req_tick & fifo_full & ~pop;
    assign busy  = (cur_state != IDLE);
    assign state = cur_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Strobe protocol: crypto_start/tx_start are single-cycle pulses, and each
    // is answered by exactly one single-cycle done pulse that is only honoured
    // in the matching wait state; the data outputs hold between the two.
    always_comb begin
        next_state   = cur_state;
        pop          = 1'b0;
        crypto_start = 1'b0;
        tx_start     = 1'b0;
        done_hit     = 1'b0;
        timeout      = 1'b0;
        case (cur_state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                crypto_start = 1'b1;
                next_state   = WAIT_C;
            end
            WAIT_C: begin
                if (crypto_done) begin
                    done_hit   = 1'b1;
                    next_state = SEND;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout    = 1'b1;
                    next_state = IDLE;
                end
            end
            SEND: begin
                tx_start   = 1'b1;
                next_state = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_tick) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt     <= '0;
            crypto_pt   <= '0;
            tx_din      <= '0;
            last_plain  <= '0;
            last_cipher <= '0;
            ovf         <= 1'b0;
            tmo_err     <= 1'b0;
        end else begin
            // The counter value equals the number of WAIT_C cycles already spent.
            if (cur_state == WAIT_C) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (pop) begin
                crypto_pt <= fifo_dout;
            end
            if (done_hit) begin
                tx_din      <= cipher_text;
                last_cipher <= cipher_text;
                last_plain  <= crypto_pt;
            end
            // A set event in the same cycle wins over err_clr.
            if (drop) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end
            if (timeout) begin
                tmo_err <= 1'b1;
            end else if (err_clr) begin
                tmo_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crypto_tx_sequencer.sv
// Directed bench for crypto_tx_sequencer: the bench plays cipher and UART,
// with ciphertext chosen as plaintext ^ 0x99 (0x3C -> 0xA5).
module tb_crypto_tx_sequencer;
    import crypto_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_tick;
    logic [7:0] plain_text;
    logic       crypto_start;
    logic [7:0] crypto_pt;
    logic       crypto_done;
    logic [7:0] cipher_text;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       tx_done_tick;
    logic [7:0] last_plain;
    logic [7:0] last_cipher;
    logic       busy;
    logic       ovf;
    logic       tmo_err;
    logic       err_clr;
    logic [2:0] state;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    crypto_tx_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req_tick    (req_tick),
        .plain_text  (plain_text),
        .crypto_start(crypto_start),
        .crypto_pt   (crypto_pt),
        .crypto_done (crypto_done),
        .cipher_text (cipher_text),
        .tx_start    (tx_start),
        .tx_din      (tx_din),
        .tx_done_tick(tx_done_tick),
        .last_plain  (last_plain),
        .last_cipher (last_cipher),
        .busy        (busy),
        .ovf         (ovf),
        .tmo_err     (tmo_err),
        .err_clr     (err_clr),
        .state       (state),
        .level       (level)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_crypto_start"}, crypto_start, 0);
        check_eq({tag, "_tx_start"}, tx_start, 0);
        check_eq({tag, "_crypto_pt"}, crypto_pt, 0);
        check_eq({tag, "_tx_din"}, tx_din, 0);
        check_eq({tag, "_last_plain"}, last_plain, 0);
        check_eq({tag, "_last_cipher"}, last_cipher, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_ovf"}, ovf, 0);
        check_eq({tag, "_tmo_err"}, tmo_err, 0);
        check_eq({tag, "_level"}, level, 0);
        check_eq({tag, "_state"}, state, IDLE);
    endtask

    // driver tasks
    task automatic push(input logic [7:0] pt, input logic clr);
        req_tick   = 1'b1;
        plain_text = pt;
        err_clr    = clr;
        tick();
        req_tick   = 1'b0;
        plain_text = 8'h00;
        err_clr    = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!crypto_start && n < 40) begin
            tick();
            n++;
        end
        check_eq("start_seen", crypto_start, 1);
    endtask

    // Serves one transaction from its crypto_start onwards and scores it.
    task automatic serve_one(input int done_delay, input int tx_delay);
        logic [7:0] pt;
        int n;
        wait_start(n);
        check_eq("exp_q_nonempty", exp_q.size() != 0, 1);
        pt = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        check_eq("crypto_pt", crypto_pt, pt);
        tick();
        check_eq("start_width", crypto_start, 0);
        repeat (done_delay - 1) tick();
        check_eq("pt_hold", crypto_pt, pt);
        crypto_done = 1'b1;
        cipher_text = pt ^ 8'h99;
        tick();
        crypto_done = 1'b0;
        cipher_text = 8'h00;
        check_eq("tx_start", tx_start, 1);
        check_eq("tx_din", tx_din, pt ^ 8'h99);
        check_eq("last_plain", last_plain, pt);
        check_eq("last_cipher", last_cipher, pt ^ 8'h99);
        tick();
        check_eq("tx_width", tx_start, 0);
        check_eq("busy_wait_tx", busy, 1);
        repeat (tx_delay) tick();
        check_eq("tx_din_hold", tx_din, pt ^ 8'h99);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        check_eq("busy_after_tx", busy, 0);
    endtask

    task automatic count_strobes(input int cycles, output int strobes);
        strobes = 0;
        repeat (cycles) begin
            tick();
            if (crypto_start || tx_start) strobes++;
        end
    endtask

    initial begin
        int n;
        int strobes;
        logic saw_tx;
        rst          = 1'b0;
        req_tick     = 1'b0;
        plain_text   = 8'h00;
        crypto_done  = 1'b0;
        cipher_text  = 8'h00;
        tx_done_tick = 1'b0;
        err_clr      = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // single request: 0x3C -> 0xA5, start two cycles after the request
        exp_q.push_back(8'h3C);
        push(8'h3C, 1'b0);
        wait_start(n);
        check_eq("latency", n + 1, 2);
        serve_one(5, 2);
        check_eq("single_last_cipher", last_cipher, 8'hA5);
        check_eq("single_last_plain", last_plain, 8'h3C);

        // done pulses outside their wait states are ignored
        crypto_done  = 1'b1;
        tx_done_tick = 1'b1;
        cipher_text  = 8'h55;
        tick();
        crypto_done  = 1'b0;
        tx_done_tick = 1'b0;
        cipher_text  = 8'h00;
        check_eq("stray_done_state", state, IDLE);
        check_eq("stray_done_cipher", last_cipher, 8'hA5);

        // burst of five while busy: fifth dropped, err_clr in the drop cycle loses
        exp_q.push_back(8'h77);
        for (int i = 1; i <= 4; i++) exp_q.push_back(i[7:0]);
        push(8'h77, 1'b0);
        fork
            begin
                tick();
                tick();
                for (int i = 1; i <= 4; i++) push(i[7:0], 1'b0);
                check_eq("burst_full_level", level, 4);
                check_eq("burst_ovf_before", ovf, 0);
                push(8'h05, 1'b1);
                check_eq("burst_ovf_set", ovf, 1);
                check_eq("burst_level_after_drop", level, 4);
            end
            serve_one(10, 2);
        join
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("ovf_cleared", ovf, 0);
        for (int i = 0; i < 4; i++) serve_one(2 + i, 1);
        count_strobes(8, strobes);
        check_eq("burst_no_extra", strobes, 0);
        check_eq("burst_drained", level, 0);

        // full queue plus a push in the pop cycle is accepted
        exp_q.push_back(8'h10);
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'h10 + i[7:0]);
        push(8'h10, 1'b0);
        fork
            begin
                tick();
                tick();
                for (int i = 1; i <= 4; i++) push(8'h10 + i[7:0], 1'b0);
                check_eq("popfull_level", level, 4);
            end
            serve_one(10, 1);
        join
        push(8'h15, 1'b0);
        check_eq("popfull_ovf", ovf, 0);
        check_eq("popfull_level_after", level, 4);
        check_eq("popfull_state", state, START);
        for (int i = 0; i < 5; i++) serve_one(3, 1);
        check_eq("popfull_ovf_end", ovf, 0);

        // timeout: byte 0x20 never completes, 0x21 follows normally
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h21);
        push(8'h20, 1'b0);
        push(8'h21, 1'b0);
        wait_start(n);
        check_eq("tmo_pt", crypto_pt, 8'h20);
        tick();
        n = 0;
        saw_tx = 1'b0;
        while (state == WAIT_C && n < 1100) begin
            if (n == 1022) check_eq("tmo_not_early", tmo_err, 0);
            tick();
            n++;
            if (tx_start) saw_tx = 1'b1;
        end
        check_eq("tmo_cycles", n, 1023);
        check_eq("tmo_err_set", tmo_err, 1);
        check_eq("tmo_no_tx", saw_tx, 0);
        check_eq("tmo_state", state, IDLE);
        void'(exp_q.pop_front());
        serve_one(4, 1);
        check_eq("tmo_err_sticky", tmo_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("tmo_err_cleared", tmo_err, 0);

        // reset during WAIT_TX with two entries queued
        push(8'h30, 1'b0);
        push(8'h31, 1'b0);
        push(8'h32, 1'b0);
        check_eq("rst_pre_level", level, 2);
        tick();
        crypto_done = 1'b1;
        cipher_text = 8'hC3;
        tick();
        crypto_done = 1'b0;
        cipher_text = 8'h00;
        tick();
        check_eq("rst_pre_state", state, WAIT_TX);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        count_strobes(20, strobes);
        check_eq("post_rst_strobes", strobes, 0);
        check_eq("post_rst_state", state, IDLE);
        exp_q.push_back(8'h40);
        push(8'h40, 1'b0);
        serve_one(2, 1);
        check_eq("post_rst_last_plain", last_plain, 8'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
